// File: rtl/redir_quiesce_if.sv
// Handshake observation and redirection request/grant bundle for redir_quiesce.
// The slave modport is the quiesce controller; the master modport is its environment.
interface redir_quiesce_if #(
  parameter int NB_PERIPH = 8,
  parameter int LOG_NB    = 3
);
  logic [NB_PERIPH-1:0] aw_hs_i;
  logic [NB_PERIPH-1:0] b_hs_i;
  logic [NB_PERIPH-1:0] ar_hs_i;
  logic [NB_PERIPH-1:0] rlast_hs_i;
  logic                 req_valid_i;
  logic [LOG_NB-1:0]    req_target_i;
  logic                 req_ready_o;
  logic [NB_PERIPH-1:0] block_o;
  logic [NB_PERIPH-1:0] redirection_idle_o;
  logic                 grant_o;
  logic [LOG_NB-1:0]    grant_target_o;
  logic                 abort_o;
  logic                 err_o;

  modport master (
    output aw_hs_i, b_hs_i, ar_hs_i, rlast_hs_i, req_valid_i, req_target_i,
    input  req_ready_o, block_o, redirection_idle_o, grant_o, grant_target_o,
           abort_o, err_o
  );

  modport slave (
    input  aw_hs_i, b_hs_i, ar_hs_i, rlast_hs_i, req_valid_i, req_target_i,
    output req_ready_o, block_o, redirection_idle_o, grant_o, grant_target_o,
           abort_o, err_o
  );
endinterface

// File: rtl/redir_quiesce.sv
// Tracks outstanding reads/writes per peripheral and quiesces one target on
// request, answering with a one-cycle grant (drained) or abort (invalid/timeout).
module redir_quiesce #(
  parameter int NB_PERIPH = 8,
  parameter int LOG_NB    = 3,
  parameter int CNT_W     = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  redir_quiesce_if.slave  bus
);

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GRANT = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [LOG_NB-1:0] tgt_q, tgt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  wr_cnt_q [NB_PERIPH];
  logic [CNT_W-1:0]  wr_cnt_d [NB_PERIPH];
  logic [CNT_W-1:0]  rd_cnt_q [NB_PERIPH];
  logic [CNT_W-1:0]  rd_cnt_d [NB_PERIPH];
  logic              tgt_idle_s;

  // Saturating up/down step; simultaneous inc and dec cancel out.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] nxt;
    if (inc && !dec && (cnt != {CNT_W{1'b1}})) begin
      nxt = cnt + CNT_W'(1);
    end else if (dec && !inc && (cnt != {CNT_W{1'b0}})) begin
      nxt = cnt - CNT_W'(1);
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

  function automatic logic cnt_underflow(input logic [CNT_W-1:0] cnt,
                                         input logic inc, input logic dec);
    return dec && !inc && (cnt == {CNT_W{1'b0}});
  endfunction

  always_comb begin
    err_d = err_q;
    for (int i = 0; i < NB_PERIPH; i++) begin
      wr_cnt_d[i] = cnt_next(wr_cnt_q[i], bus.aw_hs_i[i], bus.b_hs_i[i]);
      rd_cnt_d[i] = cnt_next(rd_cnt_q[i], bus.ar_hs_i[i], bus.rlast_hs_i[i]);
      err_d = err_d
            | cnt_underflow(wr_cnt_q[i], bus.aw_hs_i[i], bus.b_hs_i[i])
            | cnt_underflow(rd_cnt_q[i], bus.ar_hs_i[i], bus.rlast_hs_i[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB_PERIPH; i++) begin
        wr_cnt_q[i] <= {CNT_W{1'b0}};
        rd_cnt_q[i] <= {CNT_W{1'b0}};
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NB_PERIPH; i++) begin
        wr_cnt_q[i] <= wr_cnt_d[i];
        rd_cnt_q[i] <= rd_cnt_d[i];
      end
      err_q <= err_d;
    end
  end

  always_comb begin
    tgt_idle_s = 1'b0;
    for (int i = 0; i < NB_PERIPH; i++) begin
      if (tgt_q == LOG_NB'(i)) begin
        tgt_idle_s = (wr_cnt_q[i] == {CNT_W{1'b0}}) && (rd_cnt_q[i] == {CNT_W{1'b0}});
      end else begin
        tgt_idle_s = tgt_idle_s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tgt_q   <= {LOG_NB{1'b0}};
      tmo_q   <= {TMO_W{1'b0}};
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Idle is tested before the timeout so a target draining on the last allowed cycle is granted.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i) begin
          tgt_d   = bus.req_target_i;
          tmo_d   = {TMO_W{1'b0}};
          state_d = (32'(bus.req_target_i) < 32'(NB_PERIPH)) ? ST_DRAIN : ST_ABORT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (tgt_idle_s) begin
          state_d = ST_GRANT;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ABORT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_GRANT: state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready_o        = (state_q == ST_IDLE);
    bus.grant_o            = (state_q == ST_GRANT);
    bus.abort_o            = (state_q == ST_ABORT);
    bus.grant_target_o     = tgt_q;
    bus.err_o              = err_q;
    bus.block_o            = {NB_PERIPH{1'b0}};
    bus.redirection_idle_o = {NB_PERIPH{1'b0}};
    for (int i = 0; i < NB_PERIPH; i++) begin
      bus.redirection_idle_o[i] = (wr_cnt_q[i] == {CNT_W{1'b0}}) &&
                                  (rd_cnt_q[i] == {CNT_W{1'b0}});
      bus.block_o[i] = (wr_cnt_q[i] == {CNT_W{1'b1}}) ||
                       (rd_cnt_q[i] == {CNT_W{1'b1}}) ||
                       (((state_q == ST_DRAIN) || (state_q == ST_GRANT)) &&
                        (tgt_q == LOG_NB'(i)));
    end
  end

endmodule

// File: tb/tb_redir_quiesce.sv
// Self-checking bench for redir_quiesce: direct output checks plus a scoreboard
// of expected grant/abort pulses (kind, target, cycle) matched by a monitor.
module tb_redir_quiesce;

  localparam int NB = 8;
  localparam int LB = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    logic          is_grant;
    logic [LB-1:0] tgt;
    int            at_cyc;
  } exp_t;
  exp_t sb_q[$];

  redir_quiesce_if #(.NB_PERIPH(NB), .LOG_NB(LB)) bus_if ();

  redir_quiesce #(.NB_PERIPH(NB), .LOG_NB(LB), .CNT_W(4), .TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hs(input logic [NB-1:0] aw, input logic [NB-1:0] b,
                    input logic [NB-1:0] ar, input logic [NB-1:0] rl);
    bus_if.aw_hs_i    = aw;
    bus_if.b_hs_i     = b;
    bus_if.ar_hs_i    = ar;
    bus_if.rlast_hs_i = rl;
    tick(1);
    bus_if.aw_hs_i    = '0;
    bus_if.b_hs_i     = '0;
    bus_if.ar_hs_i    = '0;
    bus_if.rlast_hs_i = '0;
  endtask

  task automatic push_exp(input logic is_grant, input logic [LB-1:0] tgt, input int at_cyc);
    exp_t e;
    e.is_grant = is_grant;
    e.tgt      = tgt;
    e.at_cyc   = at_cyc;
    sb_q.push_back(e);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_ready"}, 32'(bus_if.req_ready_o), 32'd1);
    check_eq({tag, "_block"}, 32'(bus_if.block_o), 32'h00);
    check_eq({tag, "_idle"},  32'(bus_if.redirection_idle_o), 32'hFF);
    check_eq({tag, "_grant"}, 32'(bus_if.grant_o), 32'd0);
    check_eq({tag, "_abort"}, 32'(bus_if.abort_o), 32'd0);
    check_eq({tag, "_err"},   32'(bus_if.err_o), 32'd0);
    check_eq({tag, "_gtgt"},  32'(bus_if.grant_target_o), 32'd0);
  endtask

  // Every grant/abort pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus_if.grant_o || bus_if.abort_o) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_pulse", {30'd0, bus_if.grant_o, bus_if.abort_o}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("sb_kind", {30'd0, bus_if.grant_o, bus_if.abort_o},
                 e.is_grant ? 32'd2 : 32'd1);
        check_eq("sb_target", 32'(bus_if.grant_target_o), 32'(e.tgt));
        check_eq("sb_cycle", 32'(cyc), 32'(e.at_cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus_if.aw_hs_i = '0; bus_if.b_hs_i = '0; bus_if.ar_hs_i = '0; bus_if.rlast_hs_i = '0;
    bus_if.req_valid_i = 1'b0;
    bus_if.req_target_i = '0;
    #3;
    check_reset_values("rst");
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Already-idle target: grant two cycles after acceptance.
    bus_if.req_valid_i = 1'b1;
    bus_if.req_target_i = 4'd2;
    check_eq("t1_ready", 32'(bus_if.req_ready_o), 32'd1);
    push_exp(1'b1, 4'd2, cyc + 2);
    tick(1);
    bus_if.req_valid_i = 1'b0;
    check_eq("t1_blk_c1", 32'(bus_if.block_o[2]), 32'd1);
    check_eq("t1_notready", 32'(bus_if.req_ready_o), 32'd0);
    tick(1);
    check_eq("t1_blk_c2", 32'(bus_if.block_o[2]), 32'd1);
    check_eq("t1_grant", 32'(bus_if.grant_o), 32'd1);
    tick(1);
    check_eq("t1_blk_c3", 32'(bus_if.block_o[2]), 32'd0);
    check_eq("t1_ready_back", 32'(bus_if.req_ready_o), 32'd1);

    // Drain three writes on port 5; idle coincides with timeout and must win.
    repeat (3) hs(8'h20, 8'h00, 8'h00, 8'h00);
    check_eq("t2_busy", 32'(bus_if.redirection_idle_o[5]), 32'd0);
    bus_if.req_valid_i = 1'b1;
    bus_if.req_target_i = 4'd5;
    push_exp(1'b1, 4'd5, cyc + 5);
    tick(1);
    bus_if.req_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("t2_drain_blk", 32'(bus_if.block_o[5]), 32'd1);
      check_eq("t2_no_grant", 32'(bus_if.grant_o), 32'd0);
      hs(8'h00, 8'h20, 8'h00, 8'h00);
    end
    check_eq("t2_blk_last", 32'(bus_if.block_o[5]), 32'd1);
    check_eq("t2_no_grant_last", 32'(bus_if.grant_o), 32'd0);
    tick(1);
    check_eq("t2_blk_grant", 32'(bus_if.block_o[5]), 32'd1);
    tick(1);
    check_eq("t2_blk_after", 32'(bus_if.block_o[5]), 32'd0);

    // Timeout on port 1 with a read that never completes.
    hs(8'h00, 8'h00, 8'h02, 8'h00);
    bus_if.req_valid_i = 1'b1;
    bus_if.req_target_i = 4'd1;
    push_exp(1'b0, 4'd1, cyc + 5);
    tick(1);
    bus_if.req_valid_i = 1'b0;
    tick(3);
    check_eq("t3_blk_drain", 32'(bus_if.block_o[1]), 32'd1);
    tick(1);
    check_eq("t3_abort", 32'(bus_if.abort_o), 32'd1);
    check_eq("t3_blk_abort", 32'(bus_if.block_o[1]), 32'd0);
    tick(1);
    check_eq("t3_blk_after", 32'(bus_if.block_o[1]), 32'd0);
    hs(8'h00, 8'h00, 8'h00, 8'h02);
    check_eq("t3_idle_clean", 32'(bus_if.redirection_idle_o[1]), 32'd1);

    // Simultaneous inc/dec on port 3 with count 2, then underflow.
    hs(8'h08, 8'h00, 8'h00, 8'h00);
    hs(8'h08, 8'h00, 8'h00, 8'h00);
    hs(8'h08, 8'h08, 8'h00, 8'h00);
    hs(8'h00, 8'h08, 8'h00, 8'h00);
    check_eq("t4_cnt1_busy", 32'(bus_if.redirection_idle_o[3]), 32'd0);
    check_eq("t4_no_err", 32'(bus_if.err_o), 32'd0);
    hs(8'h00, 8'h08, 8'h00, 8'h00);
    check_eq("t4_cnt0_idle", 32'(bus_if.redirection_idle_o[3]), 32'd1);
    hs(8'h00, 8'h08, 8'h00, 8'h00);
    check_eq("t4_err_set", 32'(bus_if.err_o), 32'd1);
    check_eq("t4_uf_idle", 32'(bus_if.redirection_idle_o[3]), 32'd1);
    check_eq("t4_uf_noblk", 32'(bus_if.block_o[3]), 32'd0);
    hs(8'h08, 8'h00, 8'h00, 8'h00);
    check_eq("t4_one_busy", 32'(bus_if.redirection_idle_o[3]), 32'd0);
    hs(8'h00, 8'h08, 8'h00, 8'h00);
    check_eq("t4_back_idle", 32'(bus_if.redirection_idle_o[3]), 32'd1);
    check_eq("t4_err_sticky", 32'(bus_if.err_o), 32'd1);

    // Saturation on port 0.
    for (int k = 1; k <= 16; k++) begin
      hs(8'h01, 8'h00, 8'h00, 8'h00);
      check_eq("t5_sat_blk", 32'(bus_if.block_o[0]), (k >= 15) ? 32'd1 : 32'd0);
    end
    for (int k = 1; k <= 15; k++) begin
      hs(8'h00, 8'h01, 8'h00, 8'h00);
      check_eq("t5_unsat_idle", 32'(bus_if.redirection_idle_o[0]), (k == 15) ? 32'd1 : 32'd0);
    end
    check_eq("t5_err_sticky", 32'(bus_if.err_o), 32'd1);

    // Out-of-range target aborts one cycle after acceptance.
    bus_if.req_valid_i = 1'b1;
    bus_if.req_target_i = 4'd9;
    push_exp(1'b0, 4'd9, cyc + 1);
    tick(1);
    bus_if.req_valid_i = 1'b0;
    check_eq("t6_abort", 32'(bus_if.abort_o), 32'd1);
    check_eq("t6_noblk", 32'(bus_if.block_o), 32'h00);
    tick(1);
    check_eq("t6_ready", 32'(bus_if.req_ready_o), 32'd1);

    // Reset while draining port 6 drops the request silently.
    hs(8'h40, 8'h00, 8'h00, 8'h00);
    bus_if.req_valid_i = 1'b1;
    bus_if.req_target_i = 4'd6;
    tick(1);
    bus_if.req_valid_i = 1'b0;
    check_eq("t7_blk_drain", 32'(bus_if.block_o[6]), 32'd1);
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("t7_rst");
    tick(2);
    rst_n = 1'b1;
    tick(6);
    check_eq("t7_ready_after", 32'(bus_if.req_ready_o), 32'd1);
    check_eq("t7_idle_after", 32'(bus_if.redirection_idle_o), 32'hFF);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
